sb_rx_framer: RTL and testbench
===============================

# sb_rx_framer

Sideband receive front end of the USB4 logical layer. Sits between the electrical layer's `sbrx` pin and the logical-layer sideband transaction handler. Deserialises the 1-bit-per-clock sideband stream into UART-framed bytes and strips DLE framing and stuffing. Delivers LT transactions and AT/RT payloads (CRC checked) to the downstream handler as a byte stream.

## Interface
- `MAX_PAYLOAD`, 32: maximum destuffed payload bytes per AT/RT frame, excluding the 2 CRC bytes.
- `sb_clk` in 1: sideband clock; one `sbrx` bit per cycle.
- `rst` in 1: reset; asynchronous, active-low.
- `sbrx` in 1: serial sideband input; idle high.
- `enable` in 1: 0 forces both FSMs to IDLE and suppresses all outputs.
- `rx_data` out 8: destuffed payload byte.
- `rx_valid` out 1: `rx_data` valid (1-cycle pulse).
- `rx_sop` out 1: with the first `rx_valid` of a frame.
- `rx_type` out 1: 0 = command (STX_CMD), 1 = response (STX_RSP); stable from STX until next STX.
- `rx_done` out 1: 1-cycle pulse on ETX.
- `rx_crc_ok` out 1: valid with `rx_done`.
- `rx_len` out 6: payload byte count, valid with `rx_done`.
- `lt_valid` out 1: 1-cycle pulse; LT transaction received.
- `lt_lse` out 8: LSE byte, valid with `lt_valid`.
- `rx_err` out 1: 1-cycle pulse on any framing, protocol, or overflow error.

## Operation
- Byte receiver (`sb_uart_rx`):
  - In idle, `sbrx`=0 is the start bit. The next 8 cycles are data, LSB first. The following cycle is the stop bit.
  - Stop bit=1: byte strobe. Stop bit=0: framing error. The byte is discarded, `rx_err` pulses, and the framer returns to IDLE.
- Framer FSM states: IDLE, DLE1, LT_WAIT, PAYLOAD, PAY_DLE.
- IDLE: DLE → DLE1. Any other byte is ignored.
- DLE1:
  - STX_CMD or STX_RSP → PAYLOAD. Latch type, clear count, seed CRC.
  - Byte with LSE mask match → LT_WAIT.
  - Anything else → IDLE, `rx_err`.
- LT_WAIT: byte == ~LSE → `lt_valid` with `lt_lse`. Otherwise `rx_err`. Either way → IDLE.
- PAYLOAD: DLE → PAY_DLE. Any other byte is pushed into the 2-byte holdback.
- PAY_DLE:
  - DLE → push 0xFE, → PAYLOAD.
  - ETX → finish frame, → IDLE.
  - Anything else → `rx_err`, → IDLE.
- Holdback: the last 2 destuffed bytes are CRC and are never emitted. A byte is emitted on `rx_data` only when a third byte arrives behind it.
- Frame finish:
  - The held bytes form the received CRC, low byte first.
  - `rx_len` = emitted count.
  - ETX with fewer than 2 held bytes → `rx_err`, no `rx_done`.
- Overflow: pushing byte MAX_PAYLOAD+3 → `rx_err`, → IDLE, no `rx_done`.
- CRC-16:
  - Polynomial 0x8005, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - Covers the STX byte plus destuffed payload; excludes the CRC bytes.
- Simultaneous events: `enable` falling mid-frame aborts silently (no `rx_err`). An error and a byte strobe in the same cycle cannot occur, because byte strobes are at least 10 cycles apart.

## Timing
- All outputs are registered and reset to 0 (`rx_type`, `lt_lse`, `rx_len` included). The FSMs reset to IDLE.
- Byte strobe is asserted the cycle after the stop bit is sampled.
- Framer outputs (`rx_valid`, `rx_done`, `lt_valid`, `rx_err`) are asserted 1 cycle after the byte strobe. Total: 2 cycles after the stop-bit sample.
- No backpressure: the consumer must accept every `rx_valid`.
- Asynchronous reset mid-frame: everything clears immediately. Reception resumes at the next start bit after release, and the next frame must begin with DLE.

## Configuration
- `SB_CRC_CHECK_EN` defined: CRC is computed and compared; `rx_crc_ok` reflects the match.
- `SB_CRC_CHECK_EN` undefined: no CRC logic. The holdback still strips 2 bytes, and `rx_crc_ok`=1 with every `rx_done`.

## Structure
- Shared package `sb_pkg` holds:
  - Constants: DLE=8'hFE, STX_CMD=8'h05, STX_RSP=8'h04, ETX=8'h40, LSE mask/value (8'hF8/8'h80), CRC_POLY=16'h8005, CRC_INIT=16'hFFFF.
  - The framer state enum.
  - The `crc16_byte` function.
- One sub-module: `sb_uart_rx` (bit sampler/shift register). The framer FSM, holdback, and CRC live in the top.

## Test plan
- LT: serialise FE, 80, 7F → one `lt_valid`, `lt_lse`=0x80, no `rx_err`.
- Command frame FE, 05, 11, FE, FE, 22, crcL, crcH, FE, 40 with a correct scoreboard CRC:
  - `rx_data` 11, FE, 22, with `rx_sop` on 11 and `rx_type`=0.
  - `rx_done` with `rx_len`=3 and `rx_crc_ok`=1.
- Same frame with crcL XOR 0x01 → `rx_crc_ok`=0 (macro defined), or 1 (macro undefined).
- Byte with stop bit 0 mid-payload → `rx_err` 2 cycles after the stop bit, no `rx_done`; the next valid LT is received correctly.
- 35 payload bytes with MAX_PAYLOAD=32 → `rx_err` on byte 35 push, exactly 32 `rx_valid`, no `rx_done`.
- `rst` low during payload → all outputs 0 immediately; after release, a full command frame decodes normally.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants, framer state encoding and CRC-16 helper for the sideband receive path.
package sb_pkg;

  localparam logic [7:0] DLE       = 8'hFE;
  localparam logic [7:0] STX_CMD   = 8'h05;
  localparam logic [7:0] STX_RSP   = 8'h04;
  localparam logic [7:0] ETX       = 8'h40;
  localparam logic [7:0] LSE_MASK  = 8'hF8;
  localparam logic [7:0] LSE_VALUE = 8'h80;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DLE1,
    ST_LT_WAIT,
    ST_PAYLOAD,
    ST_PAY_DLE
  } framer_state_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_DATA,
    U_STOP
  } uart_state_t;

  // MSB-first, non-reflected CRC-16 update over one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_uart_rx.sv
// Sideband UART byte receiver: start bit, 8 data bits LSB first, stop bit.
module sb_uart_rx
  import sb_pkg::*;
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbrx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  uart_state_t state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state      <= U_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!enable) begin
        state <= U_IDLE;
      end else begin
        case (state)
          U_IDLE: begin
            if (!sbrx) begin
              state   <= U_DATA;
              bit_cnt <= 3'd0;
            end
          end
          U_DATA: begin
            shift   <= {sbrx, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= U_STOP;
          end
          U_STOP: begin
            state <= U_IDLE;
            if (sbrx) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= U_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sb_rx_framer.sv
// Sideband RX framer: DLE/STX/ETX de-framing, destuffing, 2-byte CRC holdback, LT decode.
// Optional CRC comparison is enabled by defining SB_CRC_CHECK_EN.
module sb_rx_framer
  import sb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 32
)
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  input  logic       enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_type,
  output logic       rx_done,
  output logic       rx_crc_ok,
  output logic [5:0] rx_len,
  output logic       lt_valid,
  output logic [7:0] lt_lse,
  output logic       rx_err
);

  localparam logic [5:0] MAX_LEN = 6'(MAX_PAYLOAD);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  sb_uart_rx u_uart (
    .sb_clk     (sb_clk),
    .rst        (rst),
    .enable     (enable),
    .sbrx       (sbrx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  framer_state_t state;
  logic [7:0]    hold0;
  logic [7:0]    hold1;
  logic [7:0]    lse_q;
  logic [1:0]    hold_cnt;
  logic [5:0]    count;
  logic          push_req;
  logic          overflow;
`ifdef SB_CRC_CHECK_EN
  logic [15:0]   crc;
`endif

  always_comb begin
    push_req = byte_valid &&
               ((state == ST_PAYLOAD && byte_data != DLE) ||
                (state == ST_PAY_DLE && byte_data == DLE));
    overflow = (hold_cnt == 2'd2) && (count == MAX_LEN);
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      hold0     <= 8'h00;
      hold1     <= 8'h00;
      lse_q     <= 8'h00;
      hold_cnt  <= 2'd0;
      count     <= 6'd0;
`ifdef SB_CRC_CHECK_EN
      crc       <= CRC_INIT;
`endif
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_sop    <= 1'b0;
      rx_type   <= 1'b0;
      rx_done   <= 1'b0;
      rx_crc_ok <= 1'b0;
      rx_len    <= 6'd0;
      lt_valid  <= 1'b0;
      lt_lse    <= 8'h00;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_sop   <= 1'b0;
      rx_done  <= 1'b0;
      lt_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
      end else if (frame_err) begin
        rx_err <= 1'b1;
        state  <= ST_IDLE;
      end else if (byte_valid) begin
        case (state)
          ST_IDLE: begin
            if (byte_data == DLE) state <= ST_DLE1;
          end
          ST_DLE1: begin
            if (byte_data == STX_CMD || byte_data == STX_RSP) begin
              state    <= ST_PAYLOAD;
              rx_type  <= (byte_data == STX_RSP);
              count    <= 6'd0;
              hold_cnt <= 2'd0;
`ifdef SB_CRC_CHECK_EN
              crc      <= crc16_byte(CRC_INIT, byte_data);
`endif
            end else if ((byte_data & LSE_MASK) == LSE_VALUE) begin
              lse_q <= byte_data;
              state <= ST_LT_WAIT;
            end else begin
              rx_err <= 1'b1;
              state  <= ST_IDLE;
            end
          end
          ST_LT_WAIT: begin
            if (byte_data == ~lse_q) begin
              lt_valid <= 1'b1;
              lt_lse   <= lse_q;
            end else begin
              rx_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          ST_PAYLOAD: begin
            if (byte_data == DLE) state <= ST_PAY_DLE;
          end
          ST_PAY_DLE: begin
            if (byte_data == DLE) begin
              state <= ST_PAYLOAD;
            end else if (byte_data == ETX) begin
              state <= ST_IDLE;
              if (hold_cnt == 2'd2) begin
                rx_done <= 1'b1;
                rx_len  <= count;
`ifdef SB_CRC_CHECK_EN
                rx_crc_ok <= ({hold1, hold0} == crc);
`else
                rx_crc_ok <= 1'b1;
`endif
              end else begin
                rx_err <= 1'b1;
              end
            end else begin
              rx_err <= 1'b1;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase

        // Holdback push; placed after the case so an overflow overrides the state chosen above.
        if (push_req) begin
          if (overflow) begin
            rx_err <= 1'b1;
            state  <= ST_IDLE;
          end else if (hold_cnt == 2'd2) begin
            rx_data  <= hold0;
            rx_valid <= 1'b1;
            rx_sop   <= (count == 6'd0);
            count    <= count + 6'd1;
            hold0    <= hold1;
            hold1    <= byte_data;
`ifdef SB_CRC_CHECK_EN
            crc      <= crc16_byte(crc, hold0);
`endif
          end else begin
            if (hold_cnt == 2'd0) hold0 <= byte_data;
            else                  hold1 <= byte_data;
            hold_cnt <= hold_cnt + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_rx_framer.sv
// Scoreboard bench for sb_rx_framer: directed byte streams, expected events queued, monitor compares.
module tb_sb_rx_framer;

  typedef enum int {EV_DATA, EV_DONE, EV_LT, EV_ERR} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic       sop;
    logic       typ;
    logic [5:0] len;
    logic       crc_ok;
  } ev_t;

  typedef logic [7:0] byte_q_t[$];

  logic       sb_clk;
  logic       rst;
  logic       sbrx;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sop;
  logic       rx_type;
  logic       rx_done;
  logic       rx_crc_ok;
  logic [5:0] rx_len;
  logic       lt_valid;
  logic [7:0] lt_lse;
  logic       rx_err;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  sb_rx_framer #(.MAX_PAYLOAD(32)) dut (
    .sb_clk    (sb_clk),
    .rst       (rst),
    .sbrx      (sbrx),
    .enable    (enable),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sop    (rx_sop),
    .rx_type   (rx_type),
    .rx_done   (rx_done),
    .rx_crc_ok (rx_crc_ok),
    .rx_len    (rx_len),
    .lt_valid  (lt_valid),
    .lt_lse    (lt_lse),
    .rx_err    (rx_err)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t make_ev(ev_kind_t k, logic [7:0] d, logic s, logic t, logic [5:0] l, logic ok);
    ev_t e;
    e.kind = k; e.data = d; e.sop = s; e.typ = t; e.len = l; e.crc_ok = ok;
    return e;
  endfunction

  // Bit-serial LFSR form of the CRC, fed MSB first.
  function automatic logic [15:0] model_crc(input logic [7:0] stx, input byte_q_t p);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int n = 0; n <= p.size(); n++) begin
      b = (n == 0) ? stx : p[n-1];
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic pop_check(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
    end else begin
      e = exp_q.pop_front();
      check_output("event_kind", 32'(k), 32'(e.kind));
      if (k == e.kind) begin
        case (k)
          EV_DATA: begin
            check_output("rx_data", 32'(rx_data), 32'(e.data));
            check_output("rx_sop", 32'(rx_sop), 32'(e.sop));
            check_output("rx_type", 32'(rx_type), 32'(e.typ));
          end
          EV_DONE: begin
            check_output("rx_len", 32'(rx_len), 32'(e.len));
            check_output("rx_crc_ok", 32'(rx_crc_ok), 32'(e.crc_ok));
          end
          EV_LT:   check_output("lt_lse", 32'(lt_lse), 32'(e.data));
          default: ;
        endcase
      end
    end
  endtask

  always @(negedge sb_clk) begin
    if (rst) begin
      if (rx_valid) pop_check(EV_DATA);
      if (rx_done)  pop_check(EV_DONE);
      if (lt_valid) pop_check(EV_LT);
      if (rx_err)   pop_check(EV_ERR);
    end
  end

  task automatic send_bit(input logic v);
    sbrx = v;
    @(posedge sb_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good_stop);
    if (!good_stop) begin
      check_output("err_not_early", 32'(rx_err), 32'd0);
      sbrx = 1'b1;
      @(posedge sb_clk);
      #1;
      check_output("err_timing", 32'(rx_err), 32'd1);
    end
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic apply_stimulus(input byte_q_t bytes);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
  endtask

  task automatic send_stuffed(input logic [7:0] b);
    send_byte(b, 1'b1);
    if (b == 8'hFE) send_byte(8'hFE, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] stx, input byte_q_t p, input logic corrupt);
    logic [15:0] c;
    logic [7:0]  lo;
    logic        ok;
    c  = model_crc(stx, p);
    lo = c[7:0] ^ {7'd0, corrupt};
`ifdef SB_CRC_CHECK_EN
    ok = !corrupt;
`else
    ok = 1'b1;
`endif
    foreach (p[i]) exp_q.push_back(make_ev(EV_DATA, p[i], (i == 0), (stx == 8'h04), 6'd0, 1'b0));
    exp_q.push_back(make_ev(EV_DONE, 8'h00, 1'b0, 1'b0, 6'(p.size()), ok));
    send_byte(8'hFE, 1'b1);
    send_byte(stx, 1'b1);
    foreach (p[i]) send_stuffed(p[i]);
    send_stuffed(lo);
    send_stuffed(c[15:8]);
    send_byte(8'hFE, 1'b1);
    send_byte(8'h40, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t p;
    rst    = 1'b0;
    sbrx   = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge sb_clk);
    #1;
    check_output("reset_outputs",
      32'({rx_data, rx_valid, rx_sop, rx_type, rx_done, rx_crc_ok, rx_len, lt_valid, lt_lse, rx_err}), 32'd0);
    rst = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    // LT transaction
    exp_q.push_back(make_ev(EV_LT, 8'h80, 1'b0, 1'b0, 6'd0, 1'b0));
    apply_stimulus('{8'hFE, 8'h80, 8'h7F});

    // Command frame with stuffed DLE, good and corrupted CRC
    p = '{8'h11, 8'hFE, 8'h22};
    send_frame(8'h05, p, 1'b0);
    send_frame(8'h05, p, 1'b1);

    // Response frame
    p = '{8'hA5, 8'h3C, 8'h00, 8'h7E};
    send_frame(8'h04, p, 1'b0);

    // Framing error mid-payload, then a valid LT
    exp_q.push_back(make_ev(EV_ERR, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0));
    apply_stimulus('{8'hFE, 8'h05, 8'h11, 8'h22});
    send_byte(8'h33, 1'b0);
    exp_q.push_back(make_ev(EV_LT, 8'h83, 1'b0, 1'b0, 6'd0, 1'b0));
    apply_stimulus('{8'hFE, 8'h83, 8'h7C});

    // LT with wrong complement, bad byte after DLE, ETX with a single held byte
    exp_q.push_back(make_ev(EV_ERR, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0));
    apply_stimulus('{8'hFE, 8'h80, 8'h80});
    exp_q.push_back(make_ev(EV_ERR, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0));
    apply_stimulus('{8'hFE, 8'h12});
    exp_q.push_back(make_ev(EV_ERR, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0));
    apply_stimulus('{8'hFE, 8'h05, 8'hAA, 8'hFE, 8'h40});

    // Overflow: 35 payload bytes, 32 emitted, error on the 35th push
    for (int i = 0; i < 32; i++)
      exp_q.push_back(make_ev(EV_DATA, 8'(8'h10 + i), (i == 0), 1'b0, 6'd0, 1'b0));
    exp_q.push_back(make_ev(EV_ERR, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0));
    send_byte(8'hFE, 1'b1);
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < 35; i++) send_byte(8'(8'h10 + i), 1'b1);

    // Reset in the middle of a response frame
    apply_stimulus('{8'hFE, 8'h04, 8'hAA, 8'hBB});
    check_output("type_before_reset", 32'(rx_type), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    #3 rst = 1'b0;
    #1;
    check_output("outputs_in_reset",
      32'({rx_data, rx_valid, rx_sop, rx_type, rx_done, rx_crc_ok, rx_len, lt_valid, lt_lse, rx_err}), 32'd0);
    sbrx = 1'b1;
    repeat (3) @(posedge sb_clk);
    #2 rst = 1'b1;
    @(posedge sb_clk);
    #1;
    p = '{8'h11, 8'hFE, 8'h22};
    send_frame(8'h05, p, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge sb_clk);
    #1;
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
